dma_transfer_ctrl: RTL and testbench

Sequences a single granted DMA channel through the 8237-style transfer states (SI, S0, S1, S2, S3, SW, S4). It sits between the channel priority block, which supplies the winning request, and the system bus pins. It owns the HRQ/HLDA handshake, DACK, the AEN/ADSTB address phase, the read/write command strobes, and address/count stepping. At service end it writes the updated address/count back and pulses the priority rotation.

---
 rtl/dma_ctrl_pkg.sv | 35 +++
 rtl/dma_transfer_ctrl_addr_count.sv | 64 ++++++
 rtl/dma_transfer_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dma_transfer_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ctrl_pkg.sv
// Shared encodings for the DMA transfer controller:
// state codes, mode/type enums and modeReg field positions.
package dma_ctrl_pkg;

  localparam logic [2:0] ST_SI = 3'd0;
  localparam logic [2:0] ST_S0 = 3'd1;
  localparam logic [2:0] ST_S1 = 3'd2;
  localparam logic [2:0] ST_S2 = 3'd3;
  localparam logic [2:0] ST_S3 = 3'd4;
  localparam logic [2:0] ST_SW = 3'd5;
  localparam logic [2:0] ST_S4 = 3'd6;
  localparam logic [2:0] ST_SC = 3'd7;

  typedef enum logic [1:0] {
    XM_DEMAND  = 2'b00,
    XM_SINGLE  = 2'b01,
    XM_BLOCK   = 2'b10,
    XM_CASCADE = 2'b11
  } xfer_mode_e;

  typedef enum logic [1:0] {
    XT_VERIFY = 2'b00,
    XT_WRITE  = 2'b01,
    XT_READ   = 2'b10,
    XT_RSVD   = 2'b11
  } xfer_type_e;

  localparam int MODE_HI  = 5;
  localparam int MODE_LO  = 4;
  localparam int MODE_DEC = 3;
  localparam int MODE_AI  = 2;
  localparam int TYPE_HI  = 1;
  localparam int TYPE_LO  = 0;

endpackage

// File: rtl/dma_transfer_ctrl_addr_count.sv
// Latched address/count for the active service: stepping, TC and
// upper-address change flags, and autoinit write-back selection.
module dma_addr_count (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_dec,
  input  logic        i_autoinit,
  input  logic        i_term,
  input  logic [15:0] i_curAddr,
  input  logic [15:0] i_curCount,
  input  logic [15:0] i_baseAddr,
  input  logic [15:0] i_baseCount,
  output logic [15:0] o_addr,
  output logic [15:0] o_wbAddr,
  output logic [15:0] o_wbCount,
  output logic        o_tcNow,
  output logic        o_tc,
  output logic        o_upChg
);

  logic [15:0] r_addr;
  logic [15:0] r_count;
  logic [15:0] r_baseAddr;
  logic [15:0] r_baseCount;
  logic        r_tc;
  logic        r_upChg;
  logic [15:0] w_addrNext;

  assign w_addrNext = i_dec ? r_addr - 16'd1 : r_addr + 16'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr      <= '0;
      r_count     <= '0;
      r_baseAddr  <= '0;
      r_baseCount <= '0;
      r_tc        <= 1'b0;
      r_upChg     <= 1'b0;
    end else if (i_load) begin
      r_addr      <= i_curAddr;
      r_count     <= i_curCount;
      r_baseAddr  <= i_baseAddr;
      r_baseCount <= i_baseCount;
      r_tc        <= 1'b0;
      r_upChg     <= 1'b0;
    end else if (i_step) begin
      r_addr  <= w_addrNext;
      r_count <= r_count - 16'd1;
      r_tc    <= (r_count == 16'd0);
      r_upChg <= (w_addrNext[15:8] != r_addr[15:8]);
    end
  end

  // Autoinit reloads only when the service is terminating.
  assign o_wbAddr  = (i_term && i_autoinit) ? r_baseAddr : r_addr;
  assign o_wbCount = (i_term && i_autoinit) ? r_baseCount : r_count;
  assign o_addr    = r_addr;
  assign o_tcNow   = (r_count == 16'd0);
  assign o_tc      = r_tc;
  assign o_upChg   = r_upChg;

endmodule

// File: rtl/dma_transfer_ctrl.sv
// 8237-style transfer sequencer for one granted channel: HRQ/DACK,
// address phase, bus strobes, stepping and register write-back.
module dma_transfer_ctrl
  import dma_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        reqValid,
  input  logic [1:0]  reqCh,
  input  logic        dreqHeld,
  input  logic        HLDA,
  input  logic        READY,
  input  logic        EOP_in_n,
  input  logic [5:0]  modeReg,
  input  logic [15:0] curAddr,
  input  logic [15:0] curCount,
  input  logic [15:0] baseAddr,
  input  logic [15:0] baseCount,
  output logic        HRQ,
  output logic        dackValid,
  output logic [1:0]  dackCh,
  output logic        AEN,
  output logic        ADSTB,
  output logic [15:0] addrOut,
  output logic        MEMR_n,
  output logic        MEMW_n,
  output logic        IOR_n,
  output logic        IOW_n,
  output logic        EOP_out_n,
  output logic        wbValid,
  output logic [1:0]  wbCh,
  output logic [15:0] wbAddr,
  output logic [15:0] wbCount,
  output logic        tcSet,
  output logic        serviceDone
);

  logic [2:0]  r_state;
  logic [1:0]  r_ch;
  logic [5:0]  r_mode;
  logic        r_term;
  logic        r_hrq, r_dack, r_aen, r_adstb;
  logic [1:0]  r_dackCh, r_wbCh;
  logic [15:0] r_addrOut, r_wbAddr, r_wbCount;
  logic        r_memr, r_memw, r_ior, r_iow, r_eopOut;
  logic        r_wbValid, r_tcSet, r_done;

  logic [2:0]  w_nstate;
  logic        w_load, w_step;
  logic        w_eopHit, w_inXfer, w_term, w_end;
  logic        w_dackN, w_aenN, w_rdCmd, w_wrCmd;
  logic        w_fromXfer, w_fromCasc, w_newAddr;
  logic [15:0] w_addr, w_wbAddr, w_wbCount;
  logic        w_tcNow, w_tc, w_upChg;
  xfer_mode_e  w_mode;
  xfer_type_e  w_type;

  assign w_mode = xfer_mode_e'(r_mode[MODE_HI:MODE_LO]);
  assign w_type = xfer_type_e'(r_mode[TYPE_HI:TYPE_LO]);

  dma_addr_count u_ac (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dec      (r_mode[MODE_DEC]),
    .i_autoinit (r_mode[MODE_AI]),
    .i_term     (w_term),
    .i_curAddr  (curAddr),
    .i_curCount (curCount),
    .i_baseAddr (baseAddr),
    .i_baseCount(baseCount),
    .o_addr     (w_addr),
    .o_wbAddr   (w_wbAddr),
    .o_wbCount  (w_wbCount),
    .o_tcNow    (w_tcNow),
    .o_tc       (w_tc),
    .o_upChg    (w_upChg)
  );

  assign w_inXfer = r_state inside {ST_S1, ST_S2, ST_S3, ST_SW, ST_S4};
  assign w_eopHit = !EOP_in_n && (r_state inside {ST_S2, ST_S3, ST_SW});
  // Lost HLDA, external EOP and TC all end the service after S4.
  assign w_term = r_term || w_tc || !HLDA;
  assign w_end  = w_term || (w_mode == XM_SINGLE) ||
                  ((w_mode == XM_DEMAND) && !dreqHeld);

  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      ST_SI: begin
        if (reqValid) begin
          w_nstate = ST_S0;
          w_load   = 1'b1;
        end
      end
      ST_S0: begin
        if (HLDA)
          w_nstate = (w_mode == XM_CASCADE) ? ST_SC : ST_S1;
      end
      ST_SC: if (!dreqHeld) w_nstate = ST_SI;
      ST_S1: w_nstate = ST_S2;
      ST_S2: w_nstate = ST_S3;
      ST_S3, ST_SW: begin
        if (READY) begin
          w_nstate = ST_S4;
          w_step   = 1'b1;
        end else begin
          w_nstate = ST_SW;
        end
      end
      ST_S4: begin
        if (w_end)        w_nstate = ST_SI;
        else if (w_upChg) w_nstate = ST_S1;
        else              w_nstate = ST_S2;
      end
      default: w_nstate = ST_SI;
    endcase
  end

  assign w_dackN = w_nstate inside {ST_S1, ST_S2, ST_S3, ST_SW, ST_S4, ST_SC};
  assign w_aenN  = w_nstate inside {ST_S1, ST_S2, ST_S3, ST_SW, ST_S4};
  assign w_rdCmd = w_nstate inside {ST_S2, ST_S3, ST_SW};
  assign w_wrCmd = w_nstate inside {ST_S3, ST_SW};
  assign w_fromXfer = (r_state == ST_S4) && (w_nstate == ST_SI);
  assign w_fromCasc = (r_state == ST_SC) && (w_nstate == ST_SI);
  assign w_newAddr  = (w_nstate == ST_S1) ||
                      ((r_state == ST_S4) && (w_nstate == ST_S2));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_SI;
      r_ch    <= '0;
      r_mode  <= '0;
      r_term  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (w_load) begin
        r_ch   <= reqCh;
        r_mode <= modeReg;
        r_term <= 1'b0;
      end else if (w_eopHit || (w_inXfer && !HLDA)) begin
        r_term <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hrq     <= 1'b0;
      r_dack    <= 1'b0;
      r_dackCh  <= '0;
      r_aen     <= 1'b0;
      r_adstb   <= 1'b0;
      r_addrOut <= '0;
      r_memr    <= 1'b1;
      r_memw    <= 1'b1;
      r_ior     <= 1'b1;
      r_iow     <= 1'b1;
      r_eopOut  <= 1'b1;
      r_wbValid <= 1'b0;
      r_wbCh    <= '0;
      r_wbAddr  <= '0;
      r_wbCount <= '0;
      r_tcSet   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_hrq    <= (w_nstate != ST_SI);
      r_dack   <= w_dackN;
      r_dackCh <= w_dackN ? r_ch : 2'd0;
      r_aen    <= w_aenN;
      r_adstb  <= (w_nstate == ST_S1);
      if (w_newAddr)             r_addrOut <= w_addr;
      else if (w_nstate == ST_SI) r_addrOut <= '0;
      r_memr   <= !(w_rdCmd && (w_type == XT_READ));
      r_ior    <= !(w_rdCmd && (w_type == XT_WRITE));
      r_iow    <= !(w_wrCmd && (w_type == XT_READ));
      r_memw   <= !(w_wrCmd && (w_type == XT_WRITE));
      r_eopOut <= !((w_nstate == ST_S4) && w_tcNow);
      r_wbValid <= w_fromXfer;
      r_tcSet   <= w_fromXfer && w_tc;
      r_done    <= w_fromXfer || w_fromCasc;
      if (w_fromXfer) begin
        r_wbCh    <= r_ch;
        r_wbAddr  <= w_wbAddr;
        r_wbCount <= w_wbCount;
      end
    end
  end

  assign HRQ         = r_hrq;
  assign dackValid   = r_dack;
  assign dackCh      = r_dackCh;
  assign AEN         = r_aen;
  assign ADSTB       = r_adstb;
  assign addrOut     = r_addrOut;
  assign MEMR_n      = r_memr;
  assign MEMW_n      = r_memw;
  assign IOR_n       = r_ior;
  assign IOW_n       = r_iow;
  assign EOP_out_n   = r_eopOut;
  assign wbValid     = r_wbValid;
  assign wbCh        = r_wbCh;
  assign wbAddr      = r_wbAddr;
  assign wbCount     = r_wbCount;
  assign tcSet       = r_tcSet;
  assign serviceDone = r_done;

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Directed bench for dma_transfer_ctrl: single/block/demand/cascade
// services, wait states, EOP, autoinit and mid-transfer reset.
module tb_dma_transfer_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        reqValid;
  logic [1:0]  reqCh;
  logic        dreqHeld;
  logic        HLDA;
  logic        READY;
  logic        EOP_in_n;
  logic [5:0]  modeReg;
  logic [15:0] curAddr, curCount, baseAddr, baseCount;
  logic        HRQ, dackValid, AEN, ADSTB;
  logic [1:0]  dackCh, wbCh;
  logic [15:0] addrOut, wbAddr, wbCount;
  logic        MEMR_n, MEMW_n, IOR_n, IOW_n, EOP_out_n;
  logic        wbValid, tcSet, serviceDone;

  int n_checks = 0;
  int n_fail   = 0;

  dma_transfer_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .reqValid   (reqValid),
    .reqCh      (reqCh),
    .dreqHeld   (dreqHeld),
    .HLDA       (HLDA),
    .READY      (READY),
    .EOP_in_n   (EOP_in_n),
    .modeReg    (modeReg),
    .curAddr    (curAddr),
    .curCount   (curCount),
    .baseAddr   (baseAddr),
    .baseCount  (baseCount),
    .HRQ        (HRQ),
    .dackValid  (dackValid),
    .dackCh     (dackCh),
    .AEN        (AEN),
    .ADSTB      (ADSTB),
    .addrOut    (addrOut),
    .MEMR_n     (MEMR_n),
    .MEMW_n     (MEMW_n),
    .IOR_n      (IOR_n),
    .IOW_n      (IOW_n),
    .EOP_out_n  (EOP_out_n),
    .wbValid    (wbValid),
    .wbCh       (wbCh),
    .wbAddr     (wbAddr),
    .wbCount    (wbCount),
    .tcSet      (tcSet),
    .serviceDone(serviceDone)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic block_run(input logic ai, input logic [15:0] expA,
                           input logic [15:0] expC, input string nm);
    modeReg   = ai ? 6'b100101 : 6'b100001;
    curAddr   = 16'h00FF;
    curCount  = 16'h0001;
    baseAddr  = 16'h4000;
    baseCount = 16'h0010;
    reqCh     = 2'd1;
    reqValid  = 1'b1;
    tick();
    reqValid = 1'b0;
    HLDA     = 1'b1;
    tick();
    chk16({nm, "_s1_addr"}, addrOut, 16'h00FF);
    tick();
    chk1({nm, "_s2_ior"}, IOR_n, 1'b0);
    chk1({nm, "_s2_memw"}, MEMW_n, 1'b1);
    tick();
    chk1({nm, "_s3_memw"}, MEMW_n, 1'b0);
    tick();
    chk1({nm, "_s4a_eop"}, EOP_out_n, 1'b1);
    tick();
    chk1({nm, "_s1b_adstb"}, ADSTB, 1'b1);
    chk16({nm, "_s1b_addr"}, addrOut, 16'h0100);
    tick();
    tick();
    tick();
    chk1({nm, "_s4b_eop"}, EOP_out_n, 1'b0);
    tick();
    chk1({nm, "_wbv"}, wbValid, 1'b1);
    chk1({nm, "_tcset"}, tcSet, 1'b1);
    chk16({nm, "_wbaddr"}, wbAddr, expA);
    chk16({nm, "_wbcnt"}, wbCount, expC);
    chk1({nm, "_hrq_off"}, HRQ, 1'b0);
    HLDA = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; reqValid = 1'b0; reqCh = 2'd0; dreqHeld = 1'b0;
    HLDA = 1'b0; READY = 1'b1; EOP_in_n = 1'b1; modeReg = '0;
    curAddr = '0; curCount = '0; baseAddr = '0; baseCount = '0;
    tick();
    tick();
    chk1("rst_hrq", HRQ, 1'b0);
    chk1("rst_dack", dackValid, 1'b0);
    chk1("rst_aen", AEN, 1'b0);
    chk16("rst_addr", addrOut, 16'h0000);
    chk1("rst_memr", MEMR_n, 1'b1);
    chk1("rst_iow", IOW_n, 1'b1);
    chk1("rst_eop", EOP_out_n, 1'b1);
    chk1("rst_wbv", wbValid, 1'b0);
    RESET = 1'b0;
    tick();

    // single read, HLDA two cycles after HRQ
    modeReg = 6'b010010; curAddr = 16'h1234; curCount = 16'h0002;
    reqCh = 2'd2; reqValid = 1'b1;
    tick();
    chk1("sr_hrq", HRQ, 1'b1);
    chk1("sr_s0_dack", dackValid, 1'b0);
    reqValid = 1'b0;
    tick();
    HLDA = 1'b1;
    tick();
    chk1("sr_s1_aen", AEN, 1'b1);
    chk1("sr_s1_adstb", ADSTB, 1'b1);
    chk16("sr_s1_addr", addrOut, 16'h1234);
    chk1("sr_s1_dack", dackValid, 1'b1);
    chk16("sr_s1_dackch", {14'd0, dackCh}, 16'd2);
    chk1("sr_s1_memr", MEMR_n, 1'b1);
    tick();
    chk1("sr_s2_memr", MEMR_n, 1'b0);
    chk1("sr_s2_iow", IOW_n, 1'b1);
    chk1("sr_s2_adstb", ADSTB, 1'b0);
    tick();
    chk1("sr_s3_memr", MEMR_n, 1'b0);
    chk1("sr_s3_iow", IOW_n, 1'b0);
    tick();
    chk1("sr_s4_memr", MEMR_n, 1'b1);
    chk1("sr_s4_iow", IOW_n, 1'b1);
    chk1("sr_s4_eop", EOP_out_n, 1'b1);
    tick();
    chk1("sr_wbv", wbValid, 1'b1);
    chk1("sr_done", serviceDone, 1'b1);
    chk1("sr_tcset", tcSet, 1'b0);
    chk16("sr_wbaddr", wbAddr, 16'h1235);
    chk16("sr_wbcnt", wbCount, 16'h0001);
    chk16("sr_wbch", {14'd0, wbCh}, 16'd2);
    chk1("sr_hrq_off", HRQ, 1'b0);
    chk1("sr_aen_off", AEN, 1'b0);
    HLDA = 1'b0;
    tick();
    chk1("sr_wbv_pulse", wbValid, 1'b0);

    block_run(1'b0, 16'h0101, 16'hFFFF, "blk");
    block_run(1'b1, 16'h4000, 16'h0010, "blkai");

    // READY low for three cycles starting in S3
    modeReg = 6'b010010; curAddr = 16'h2000; curCount = 16'h0005;
    reqCh = 2'd0; reqValid = 1'b1;
    tick();
    reqValid = 1'b0; HLDA = 1'b1;
    tick();
    tick();
    tick();
    READY = 1'b0;
    tick();
    chk1("rdy_sw1_iow", IOW_n, 1'b0);
    tick();
    chk1("rdy_sw2_memr", MEMR_n, 1'b0);
    tick();
    chk1("rdy_sw3_iow", IOW_n, 1'b0);
    READY = 1'b1;
    tick();
    chk1("rdy_s4_iow", IOW_n, 1'b1);
    tick();
    chk1("rdy_wbv", wbValid, 1'b1);
    chk16("rdy_wbaddr", wbAddr, 16'h2001);
    chk16("rdy_wbcnt", wbCount, 16'h0004);
    HLDA = 1'b0;
    tick();

    // demand mode, DREQ dropped during second S4
    modeReg = 6'b000010; curAddr = 16'h3000; curCount = 16'h0010;
    dreqHeld = 1'b1; reqValid = 1'b1;
    tick();
    reqValid = 1'b0; HLDA = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk1("dm_s2b_adstb", ADSTB, 1'b0);
    chk1("dm_s2b_memr", MEMR_n, 1'b0);
    chk16("dm_s2b_addr", addrOut, 16'h3001);
    tick();
    tick();
    dreqHeld = 1'b0;
    chk1("dm_s4b_wbv", wbValid, 1'b0);
    tick();
    chk1("dm_wbv", wbValid, 1'b1);
    chk16("dm_wbaddr", wbAddr, 16'h3002);
    chk16("dm_wbcnt", wbCount, 16'h000E);
    HLDA = 1'b0;
    tick();

    // demand mode, external EOP in first S2
    curAddr = 16'h3100; dreqHeld = 1'b1; reqValid = 1'b1;
    tick();
    reqValid = 1'b0; HLDA = 1'b1;
    tick();
    tick();
    EOP_in_n = 1'b0;
    tick();
    EOP_in_n = 1'b1;
    tick();
    chk1("eop_s4_eopout", EOP_out_n, 1'b1);
    tick();
    chk1("eop_wbv", wbValid, 1'b1);
    chk1("eop_tcset", tcSet, 1'b0);
    chk16("eop_wbaddr", wbAddr, 16'h3101);
    chk16("eop_wbcnt", wbCount, 16'h000F);
    HLDA = 1'b0; dreqHeld = 1'b0;
    tick();

    // reset asserted in S3
    modeReg = 6'b010010; curAddr = 16'h5000; curCount = 16'h0003;
    reqValid = 1'b1;
    tick();
    reqValid = 1'b0; HLDA = 1'b1;
    tick();
    tick();
    tick();
    chk1("rs_s3_iow", IOW_n, 1'b0);
    RESET = 1'b1;
    tick();
    chk1("rs_hrq", HRQ, 1'b0);
    chk1("rs_dack", dackValid, 1'b0);
    chk1("rs_aen", AEN, 1'b0);
    chk1("rs_memr", MEMR_n, 1'b1);
    chk1("rs_iow", IOW_n, 1'b1);
    chk1("rs_wbv", wbValid, 1'b0);
    chk1("rs_done", serviceDone, 1'b0);
    RESET = 1'b0; HLDA = 1'b0;
    tick();
    chk1("rs_after_wbv", wbValid, 1'b0);

    // cascade hold
    modeReg = 6'b110000; reqCh = 2'd3; dreqHeld = 1'b1; reqValid = 1'b1;
    tick();
    reqValid = 1'b0; HLDA = 1'b1;
    tick();
    chk1("cas_dack", dackValid, 1'b1);
    chk16("cas_dackch", {14'd0, dackCh}, 16'd3);
    chk1("cas_aen", AEN, 1'b0);
    tick();
    tick();
    chk1("cas_hold_dack", dackValid, 1'b1);
    chk1("cas_memr", MEMR_n, 1'b1);
    chk1("cas_iow", IOW_n, 1'b1);
    dreqHeld = 1'b0;
    tick();
    chk1("cas_end_dack", dackValid, 1'b0);
    chk1("cas_end_hrq", HRQ, 1'b0);
    chk1("cas_done", serviceDone, 1'b1);
    chk1("cas_wbv", wbValid, 1'b0);
    HLDA = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
